// File: rtl/shift_reg2_sequencer.sv
// Command sequencer for shift_reg2: optional load, then N shift steps, then a done pulse.
// Optional abort input enabled by defining SHREG_SEQ_ABORT_EN.
module shift_reg2_sequencer #(
    parameter int          CW       = 4,
    parameter logic [2:0]  DIR_LOAD = 3'b011
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [2:0]    cmd_dir,
    input  logic [CW-1:0] cmd_count,
    input  logic [7:0]    cmd_data,
    input  logic          pause,
`ifdef SHREG_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          sr_enable,
    output logic [2:0]    sr_dir,
    output logic [7:0]    sr_data_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] steps_left
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t        r_state;
    logic [2:0]    r_dir;
    logic          w_abort;
    logic [CW-1:0] w_cnt;

`ifdef SHREG_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // A shift code equal to the load code would reload, so it runs no steps.
    assign w_cnt = (cmd_dir == DIR_LOAD) ? '0 : cmd_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dir      <= 3'b000;
            cmd_ready  <= 1'b1;
            sr_enable  <= 1'b0;
            sr_dir     <= 3'b000;
            sr_data_in <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        sr_data_in <= cmd_data;
                        r_dir      <= cmd_dir;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        steps_left <= w_cnt;
                        if (cmd_load) begin
                            r_state   <= LOAD;
                            sr_enable <= 1'b1;
                            sr_dir    <= DIR_LOAD;
                        end else if (w_cnt != '0) begin
                            r_state   <= SHIFT;
                            sr_enable <= ~pause;
                            sr_dir    <= cmd_dir;
                        end else begin
                            r_state   <= DONE;
                            sr_enable <= 1'b0;
                            sr_dir    <= 3'b000;
                            done      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (!w_abort && steps_left != '0) begin
                        r_state   <= SHIFT;
                        sr_enable <= ~pause;
                        sr_dir    <= r_dir;
                    end else begin
                        r_state    <= DONE;
                        sr_enable  <= 1'b0;
                        sr_dir     <= 3'b000;
                        done       <= 1'b1;
                        steps_left <= '0;
                    end
                end
                SHIFT: begin
                    // steps_left counts the step being issued this cycle.
                    if (w_abort || (sr_enable && steps_left == CW'(1))) begin
                        r_state    <= DONE;
                        sr_enable  <= 1'b0;
                        sr_dir     <= 3'b000;
                        done       <= 1'b1;
                        steps_left <= '0;
                    end else begin
                        sr_enable <= ~pause;
                        if (sr_enable) begin
                            steps_left <= steps_left - CW'(1);
                        end
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg2_sequencer.sv
// Self-checking bench for shift_reg2_sequencer: directed table, corner sequences, random vs model.
module tb_shift_reg2_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_dir;
    logic [3:0] cmd_count;
    logic [7:0] cmd_data;
    logic       pause;
`ifdef SHREG_SEQ_ABORT_EN
    logic       abort;
`endif
    logic       sr_enable;
    logic [2:0] sr_dir;
    logic [7:0] sr_data_in;
    logic       busy;
    logic       done;
    logic [3:0] steps_left;

    int checks = 0;
    int errors = 0;

    shift_reg2_sequencer #(.CW(4), .DIR_LOAD(3'b011)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_load(cmd_load),
        .cmd_dir(cmd_dir),
        .cmd_count(cmd_count),
        .cmd_data(cmd_data),
        .pause(pause),
`ifdef SHREG_SEQ_ABORT_EN
        .abort(abort),
`endif
        .sr_enable(sr_enable),
        .sr_dir(sr_dir),
        .sr_data_in(sr_data_in),
        .busy(busy),
        .done(done),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_ready"}, 64'(cmd_ready), 64'd1);
        check({nm, "_en"}, 64'(sr_enable), 64'd0);
        check({nm, "_dir"}, 64'(sr_dir), 64'd0);
        check({nm, "_data"}, 64'(sr_data_in), 64'h00);
        check({nm, "_busy"}, 64'(busy), 64'd0);
        check({nm, "_done"}, 64'(done), 64'd0);
        check({nm, "_sl"}, 64'(steps_left), 64'd0);
    endtask

    // Issue one command from IDLE; pm[k] is the pause value at edge k (edge 0 = accept).
    // Result: edge index after which done is high, enable count, per-edge enable trace.
    task automatic run_cmd(input logic ld, input logic [2:0] dr,
                           input logic [3:0] cn, input logic [7:0] dt,
                           input logic [63:0] pm, output int de,
                           output int ne, output logic [63:0] tr);
        int ceff;
        int sh;
        ceff = (dr == 3'b011) ? 0 : int'(cn);
        sh = 0;
        de = -1;
        ne = 0;
        tr = '0;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_dir   = dr;
        cmd_count = cn;
        cmd_data  = dt;
        pause     = pm[0];
        for (int k = 0; k < 60 && de < 0; k++) begin
            tick();
            cmd_valid = 1'b0;
            pause = pm[k+1];
            check("busy", 64'(busy), 64'd1);
            check("ready", 64'(cmd_ready), 64'd0);
            check("data", 64'(sr_data_in), 64'(dt));
            if (sr_enable) begin
                ne++;
                tr[k] = 1'b1;
                if (ld && k == 0) begin
                    check("load_dir", 64'(sr_dir), 64'd3);
                end else begin
                    check("shift_dir", 64'(sr_dir), 64'(dr));
                    check("steps_left", 64'(steps_left), 64'(ceff - sh));
                    sh++;
                end
            end
            if (done) begin
                de = k;
                check("done_sl", 64'(steps_left), 64'd0);
                check("done_dir", 64'(sr_dir), 64'd0);
            end
        end
        pause = 1'b0;
        if (de < 0) check("timeout", 64'd0, 64'd1);
        tick();
        check("idle_ready", 64'(cmd_ready), 64'd1);
        check("idle_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    // Reference: load takes one cycle; each shift cycle issues a step unless
    // pause was high at the edge that opened it; done follows the last step.
    task automatic model(input logic ld, input logic [2:0] dr,
                         input logic [3:0] cn, input logic [63:0] pm,
                         output int de, output int ne, output logic [63:0] tr);
        int k;
        int rem;
        tr  = '0;
        ne  = 0;
        rem = (dr == 3'b011) ? 0 : int'(cn);
        k   = ld ? 1 : 0;
        if (ld) begin
            tr[0] = 1'b1;
            ne = 1;
        end
        while (rem > 0) begin
            if (!pm[k]) begin
                tr[k] = 1'b1;
                ne++;
                rem--;
            end
            k++;
        end
        de = k;
    endtask

    typedef struct {
        logic        ld;
        logic [2:0]  dr;
        logic [3:0]  cn;
        logic [7:0]  dt;
        logic [63:0] pm;
        int          de;
        int          ne;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int de, ne, mde, mne;
        logic [63:0] tr, mtr, pm;
        logic ld;
        logic [2:0] dr;
        logic [3:0] cn;
        logic [7:0] dt;
        logic [4:0] e_en, e_done, e_rdy;
        logic [7:0] e_dat [5];

        tbl[0] = '{1'b1, 3'd0, 4'd0,  8'hA5, 64'h0, 1, 1};
        tbl[1] = '{1'b0, 3'd0, 4'd3,  8'h3C, 64'h0, 3, 3};
        tbl[2] = '{1'b0, 3'd1, 4'd4,  8'h5A, 64'h2, 5, 4};
        tbl[3] = '{1'b1, 3'd2, 4'd2,  8'hFF, 64'h0, 3, 3};
        tbl[4] = '{1'b0, 3'd3, 4'd5,  8'h11, 64'h0, 0, 0};
        tbl[5] = '{1'b0, 3'd4, 4'd0,  8'h22, 64'h0, 0, 0};
        tbl[6] = '{1'b1, 3'd5, 4'd3,  8'h77, 64'h1, 4, 4};
        tbl[7] = '{1'b0, 3'd6, 4'd15, 8'h99, 64'h0, 15, 15};
        tbl[8] = '{1'b0, 3'd7, 4'd2,  8'h01, 64'h1, 3, 2};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_load = 1'b0;
        cmd_dir = 3'd0;
        cmd_count = 4'd0;
        cmd_data = 8'h00;
        pause = 1'b0;
`ifdef SHREG_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        check_reset_vals("rst");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_vals("post_rst");

        foreach (tbl[i]) begin
            run_cmd(tbl[i].ld, tbl[i].dr, tbl[i].cn, tbl[i].dt, tbl[i].pm,
                    de, ne, tr);
            check($sformatf("tbl%0d_done_edge", i), 64'(de), 64'(tbl[i].de));
            check($sformatf("tbl%0d_enables", i), 64'(ne), 64'(tbl[i].ne));
        end

        // Reset during SHIFT after two steps.
        cmd_valid = 1'b1;
        cmd_load = 1'b0;
        cmd_dir = 3'd1;
        cmd_count = 4'd5;
        cmd_data = 8'hC3;
        tick();
        cmd_valid = 1'b0;
        check("mid_en0", 64'(sr_enable), 64'd1);
        tick();
        check("mid_en1", 64'(sr_enable), 64'd1);
        check("mid_sl", 64'(steps_left), 64'd4);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst_no_done", 64'(done), 64'd0);
        end
        reset = 1'b0;
        tick();
        check_reset_vals("rst_release");

        // cmd_valid held through two count=1 commands.
        e_en   = 5'b01001;
        e_done = 5'b10010;
        e_rdy  = 5'b00100;
        e_dat[0] = 8'h10;
        e_dat[1] = 8'h10;
        e_dat[2] = 8'h10;
        e_dat[3] = 8'h20;
        e_dat[4] = 8'h20;
        cmd_valid = 1'b1;
        cmd_dir = 3'd2;
        cmd_count = 4'd1;
        cmd_data = 8'h10;
        for (int k = 0; k < 5; k++) begin
            tick();
            cmd_data = 8'h20;
            check($sformatf("b2b_en%0d", k), 64'(sr_enable), 64'(e_en[k]));
            check($sformatf("b2b_done%0d", k), 64'(done), 64'(e_done[k]));
            check($sformatf("b2b_rdy%0d", k), 64'(cmd_ready), 64'(e_rdy[k]));
            check($sformatf("b2b_dat%0d", k), 64'(sr_data_in), 64'(e_dat[k]));
        end
        cmd_valid = 1'b0;
        tick();
        check("b2b_idle", 64'(cmd_ready), 64'd1);

`ifdef SHREG_SEQ_ABORT_EN
        cmd_valid = 1'b1;
        cmd_dir = 3'd0;
        cmd_count = 4'd7;
        cmd_data = 8'h5E;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmd_valid = 1'b0;
            check("abt_step", 64'(sr_enable), 64'd1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt_en", 64'(sr_enable), 64'd0);
        check("abt_done", 64'(done), 64'd1);
        check("abt_sl", 64'(steps_left), 64'd0);
        tick();
        check("abt_idle", 64'(cmd_ready), 64'd1);
        check("abt_nodone", 64'(done), 64'd0);
`endif

        for (int n = 0; n < 25; n++) begin
            ld = 1'($urandom_range(0, 1));
            dr = 3'($urandom_range(0, 7));
            cn = 4'($urandom_range(0, 10));
            dt = 8'($urandom);
            pm = '0;
            for (int b = 0; b < 40; b++) pm[b] = ($urandom_range(0, 3) == 0);
            model(ld, dr, cn, pm, mde, mne, mtr);
            run_cmd(ld, dr, cn, dt, pm, de, ne, tr);
            check($sformatf("rnd%0d_done_edge", n), 64'(de), 64'(mde));
            check($sformatf("rnd%0d_enables", n), 64'(ne), 64'(mne));
            check($sformatf("rnd%0d_trace", n), tr, mtr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
